// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single uart_tx engine between NUM_REQ byte requesters and owns the
// RS485 driver enable so the transceiver drives the bus only while a frame is
// in flight, plus GUARD_CYCLES of lead time before the first start and lag
// time after the last done.
//
// Parameters:
//   NUM_REQ       number of requesters (>= 2)
//   WIDTH         byte width, matches uart_tx
//   GUARD_CYCLES  en_rs485 lead/lag time in clk cycles (0 allowed)
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   req_valid  per-requester "byte pending"
//   req_data   byte of requester i in bits [i*WIDTH +: WIDTH]
//   req_ready  one-cycle accept pulse to the granted requester
//   tx_start   one-cycle start pulse to uart_tx
//   tx_data    byte to uart_tx, stable from tx_start until tx_done
//   tx_busy    uart_tx busy
//   tx_done    uart_tx frame-complete pulse
//   en_rs485   RS485 DE/nRE, high = drive
//   grant_id   index of the last granted requester
//
// Build option:
//   UART_ARB_FIXED_PRIO_EN  when defined, the lowest requesting index always
//                           wins and no round-robin pointer exists; when
//                           undefined, round-robin arbitration is used.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 8,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [WIDTH-1:0]           tx_data,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic                       en_rs485,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    // The counter is loaded with GUARD_CYCLES-1 and the state is left on the
    // cycle it reads zero, giving exactly GUARD_CYCLES cycles in LEAD/LAG.
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_LAUNCH,
        S_WAIT_DONE,
        S_LAG
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 tx_start_q, tx_start_d;
    logic [WIDTH-1:0]     tx_data_q, tx_data_d;
    logic                 en_rs485_q, en_rs485_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;

    logic                 any_req;
    logic [ID_W-1:0]      winner;
    logic                 do_grant;

`ifdef UART_ARB_FIXED_PRIO_EN
    // Fixed priority: scan downwards so the lowest set index is written last.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_req = 1'b1;
                winner  = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W:0]        rr_sum;
    logic [ID_W-1:0]      rr_idx;
    logic [ID_W-1:0]      ptr_next;

    // Round-robin: offsets scanned from the far end so the requester closest
    // to the pointer (smallest offset) is the one left in winner.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        rr_sum  = '0;
        rr_idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            rr_sum = {1'b0, ptr_q} + (ID_W + 1)'(i);
            if (rr_sum >= (ID_W + 1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (ID_W + 1)'(NUM_REQ);
            end
            rr_idx = rr_sum[ID_W-1:0];
            if (req_valid[rr_idx]) begin
                any_req = 1'b1;
                winner  = rr_idx;
            end
        end
    end

    assign ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = '0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        grant_id_d  = grant_id_q;
        do_grant    = 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    do_grant = 1'b1;
                    cnt_d    = CNT_LOAD;
                    state_d  = (GUARD_CYCLES == 0) ? S_LAUNCH : S_LEAD;
                end
            end
            S_LEAD: begin
                if (cnt_q == '0) begin
                    state_d = S_LAUNCH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_LAUNCH: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    if (any_req) begin
                        // Back-to-back: the bus is already driven, skip lead.
                        do_grant = 1'b1;
                        state_d  = S_LAUNCH;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = (GUARD_CYCLES == 0) ? S_IDLE : S_LAG;
                    end
                end
            end
            S_LAG: begin
                if (any_req) begin
                    do_grant = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_LAUNCH;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_grant) begin
            req_ready_d[winner] = 1'b1;
            tx_data_d           = req_data[int'(winner)*WIDTH +: WIDTH];
            grant_id_d          = winner;
`ifndef UART_ARB_FIXED_PRIO_EN
            ptr_d               = ptr_next;
`endif
        end
    end

    // Enable rises one cycle after leaving IDLE and falls on the edge that
    // returns to IDLE, so lead and lag are both exactly GUARD_CYCLES long.
    assign en_rs485_d = (state_q != S_IDLE) && (state_d != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            en_rs485_q  <= 1'b0;
            grant_id_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            en_rs485_q  <= en_rs485_d;
            grant_id_q  <= grant_id_d;
        end
    end

`ifndef UART_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign req_ready = req_ready_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign en_rs485  = en_rs485_q;
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed testbench for uart_tx_arbiter (NUM_REQ=4, WIDTH=8, GUARD_CYCLES=16).
// The bench plays the role of the requesters and of uart_tx. Inputs change
// 1 ns after the rising edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int G       = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     tx_start;
    logic [WIDTH-1:0]         tx_data;
    logic                     tx_busy;
    logic                     tx_done;
    logic                     en_rs485;
    logic [1:0]               grant_id;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .WIDTH        (WIDTH),
        .GUARD_CYCLES (G)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .en_rs485  (en_rs485),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_byte(input int idx, input logic [7:0] val);
        req_data[idx*WIDTH +: WIDTH] = val;
    endtask

    // Returns ticks taken until req_ready is seen (limit on timeout).
    task automatic wait_ready(input int limit, output int n);
        n = 0;
        while (req_ready == '0 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_start(input int limit, output int n);
        n = 0;
        while (!tx_start && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_en_low(input int limit, output int n);
        n = 0;
        while (en_rs485 && n < limit) begin
            tick();
            n++;
        end
    endtask

    // uart_tx model: busy for busy_cyc cycles, then a one-cycle done pulse.
    task automatic run_frame(input int busy_cyc);
        tx_busy = 1'b1;
        repeat (busy_cyc) tick();
        tx_busy = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // Continuous monitors: enable continuity during back-to-back traffic and
    // single-cycle / one-hot behaviour of the handshake pulses.
    logic               en_watch = 1'b0;
    logic               en_dropped = 1'b0;
    int                 pulse_viol = 0;
    logic [NUM_REQ-1:0] prev_ready = '0;
    logic               prev_start = 1'b0;

    always @(negedge clk) begin
        if (en_watch && !en_rs485) en_dropped = 1'b1;
        if (req_ready != '0 && prev_ready != '0) pulse_viol++;
        if ($countones(req_ready) > 1) pulse_viol++;
        if (tx_start && prev_start) pulse_viol++;
        prev_ready = req_ready;
        prev_start = tx_start;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [NUM_REQ-1:0] exp_oh;
        int exp_seq [3];

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        tick();
        tick();

        // ---------------- reset values ----------------
        check_val("rst_ready",    32'(req_ready), 32'h0);
        check_val("rst_start",    32'(tx_start),  32'h0);
        check_val("rst_data",     32'(tx_data),   32'h0);
        check_val("rst_en",       32'(en_rs485),  32'h0);
        check_val("rst_grant_id", 32'(grant_id),  32'h0);
        rst = 1'b0;
        tick();

        // ---------------- single request on index 2 ----------------
        set_byte(0, 8'h11);
        set_byte(1, 8'h22);
        set_byte(2, 8'h5A);
        set_byte(3, 8'h44);
        req_valid = 4'b0100;
        tick();
        check_val("t1_ready",    32'(req_ready), 32'h4);
        check_val("t1_grant_id", 32'(grant_id),  32'h2);
        check_val("t1_data",     32'(tx_data),   32'h5A);
        check_val("t1_en_grant", 32'(en_rs485),  32'h0);
        $display("txn: grant id=%0d data=%02h", grant_id, tx_data);
        req_valid = '0;
        tick();
        check_val("t1_en_rise", 32'(en_rs485), 32'h1);
        wait_start(40, n);
        check_val("t1_start_delay", 32'(n), 32'd16);
        check_val("t1_start_data",  32'(tx_data), 32'h5A);
        tx_busy = 1'b1;
        tick();
        check_val("t1_start_pulse", 32'(tx_start), 32'h0);
        run_frame(3);
        check_val("t1_en_after_done", 32'(en_rs485), 32'h1);
        wait_en_low(40, n);
        check_val("t1_lag_len", 32'(n), 32'd16);

        // tx_done while IDLE must not wake the arbiter
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        check_val("idle_done_en",    32'(en_rs485), 32'h0);
        check_val("idle_done_start", 32'(tx_start), 32'h0);

        // ---------------- all four requesters continuously valid ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_byte(i, 8'(8'h10 + i));
        req_valid = 4'hF;
        for (int g = 0; g < 5; g++) begin
            wait_ready(60, n);
            check_val($sformatf("t2_ready_lat%0d", g), 32'(n), (g == 0) ? 32'd1 : 32'd0);
            exp_oh = 4'b0001 << (g % NUM_REQ);
            check_val($sformatf("t2_ready%0d", g), 32'(req_ready), 32'(exp_oh));
            check_val($sformatf("t2_gid%0d", g),   32'(grant_id),  32'(g % NUM_REQ));
            check_val($sformatf("t2_data%0d", g),  32'(tx_data),   32'(8'h10 + (g % NUM_REQ)));
            $display("txn: grant id=%0d data=%02h", grant_id, tx_data);
            if (g == 4) req_valid = '0;
            wait_start(40, n);
            check_val($sformatf("t2_start_lat%0d", g), 32'(n), (g == 0) ? 32'd17 : 32'd1);
            if (g == 0) en_watch = 1'b1;
            run_frame(3);
        end

        // ---------------- request arrives 5 cycles into LAG ----------------
        repeat (4) tick();
        set_byte(1, 8'hC3);
        req_valid = 4'b0010;
        tick();
        check_val("t3_ready", 32'(req_ready), 32'h2);
        check_val("t3_data",  32'(tx_data),   32'hC3);
        $display("txn: grant id=%0d data=%02h", grant_id, tx_data);
        req_valid = '0;
        tick();
        check_val("t3_start", 32'(tx_start), 32'h1);
        check_val("t3_en_continuous", 32'(en_dropped), 32'h0);
        en_watch = 1'b0;
        run_frame(2);
        wait_en_low(40, n);
        check_val("t3_lag_len", 32'(n), 32'd16);

        // ---------------- tx_busy stays high 10 cycles past LEAD ----------------
        set_byte(2, 8'h7E);
        req_valid = 4'b0100;
        tx_busy   = 1'b1;
        tick();
        check_val("t4_ready", 32'(req_ready), 32'h4);
        $display("txn: grant id=%0d data=%02h", grant_id, tx_data);
        req_valid = '0;
        n = 0;
        repeat (25) begin
            tick();
            if (tx_start) n++;
        end
        check_val("t4_start_held", 32'(n), 32'h0);
        tx_busy = 1'b0;
        tick();
        check_val("t4_start", 32'(tx_start), 32'h1);
        check_val("t4_data",  32'(tx_data),  32'h7E);

        // ---------------- reset during WAIT_DONE ----------------
        #1;
        rst = 1'b1;
        #1;
        check_val("t5_rst_start", 32'(tx_start),  32'h0);
        check_val("t5_rst_en",    32'(en_rs485),  32'h0);
        check_val("t5_rst_data",  32'(tx_data),   32'h0);
        check_val("t5_rst_gid",   32'(grant_id),  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_byte(i, 8'(8'h10 + i));
        req_valid = 4'hF;
        tick();
        check_val("t5_first_grant", 32'(req_ready), 32'h1);
        check_val("t5_first_data",  32'(tx_data),   32'h10);
        $display("txn: grant id=%0d data=%02h", grant_id, tx_data);

        // ---------------- requests 1 and 3 held valid ----------------
        req_valid = 4'b1010;
`ifdef UART_ARB_FIXED_PRIO_EN
        exp_seq = '{1, 1, 1};
`else
        exp_seq = '{1, 3, 1};
`endif
        wait_start(40, n);
        check_val("t6_start_lat", 32'(n), 32'd17);
        for (int k = 0; k < 3; k++) begin
            run_frame(2);
            exp_oh = 4'b0001 << exp_seq[k];
            check_val($sformatf("t6_ready%0d", k), 32'(req_ready), 32'(exp_oh));
            check_val($sformatf("t6_gid%0d", k),   32'(grant_id),  32'(exp_seq[k]));
            $display("txn: grant id=%0d data=%02h", grant_id, tx_data);
            if (k == 2) req_valid = '0;
            wait_start(40, n);
            check_val($sformatf("t6_start_lat%0d", k), 32'(n), 32'd1);
        end
        run_frame(2);
        wait_en_low(40, n);
        check_val("t6_lag_len", 32'(n), 32'd16);

        check_val("pulse_rules", 32'(pulse_viol), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
